alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes alu_op, funct3 and instruction bit 30 into an extended RV32I-style operation set, executes on registered operands, and returns a registered result over a valid/ready handshake. Shifts run iteratively, so variable latency is hidden behind the handshake. It sits between the main-control decode stage and the writeback mux.

Parameters:
WIDTH, 32, operand/result width; power of two, at least 8.
INSTR_WIDTH, 32, instruction word width; at least 31.
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operation offered
in_ready  out  1  unit can accept an operation this cycle
instruccion  in  INSTR_WIDTH  instruction word; uses [14:12] and [30] (plus [31:25] with ALU_MUL_EN)
alu_op  in  2  from main control: 00 add, 01 sub, 10 R-type, 11 I-type
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B (or immediate)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
zero  out  1  result == 0, registered with result
illegal  out  1  undecodable operation; result forced to 0
busy  out  1  multi-cycle operation in progress

Behaviour:
- Reset (async, active-high): state IDLE, out_valid=0, result=0, zero=0, illegal=0, busy=0. Any in-flight operation is discarded and no output is produced.
- Accept: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Decode for alu_op 00/01: add/sub; funct3 and bit 30 are ignored.
- Decode for alu_op 10 (R-type), keyed on funct3 and bit30:
  - 000/0 ADD; 000/1 SUB; 001/0 SLL; 010/0 SLT (signed); 011/0 SLTU; 100/0 XOR.
  - 101/0 SRL; 101/1 SRA; 110/0 OR; 111/0 AND.
  - bit30=1 with any other funct3 is ILLEGAL.
- Decode for alu_op 11 (I-type): same table, except 000 is always ADD (bit30 ignored). bit30 selects SRAI only for funct3 101. 001 with bit30=1 is ILLEGAL.
- SLT/SLTU results are zero-extended 1/0. Add and sub wrap modulo 2^WIDTH; no carry or overflow output.
- FSM states IDLE, SHIFT, (MUL with macro). busy=1 in any state other than IDLE.
- IDLE, single-cycle op accepted: result, zero and illegal register at the accepting edge. out_valid=1 the next cycle (latency 1).
- IDLE, shift accepted: latch op_a and shamt = op_b[SHAMT_W-1:0].
  - shamt==0: complete like a single-cycle op (latency 1).
  - Otherwise: go to SHIFT and shift 1 bit per cycle. SRA replicates the MSB; SRL and SLL fill 0.
  - When the count reaches 0: write result, out_valid=1, return to IDLE. Latency = shamt+1 cycles from accept to out_valid.
- Output hold: while out_valid && !out_ready, result, zero and illegal stay stable. On out_valid && out_ready, out_valid clears unless a new single-cycle op is accepted the same edge (back-to-back throughput 1/cycle).
- ILLEGAL: completes in 1 cycle with result=0, zero=1, illegal=1. Never hangs.
- in_valid while in_ready=0 is ignored; the producer must hold its inputs.

Optional Feature:
ALU_MUL_EN
- Defined: alu_op 10 with instruccion[31:25]==7'b0000001 and funct3 000 is MUL (low WIDTH bits of op_a*op_b). It uses the MUL state, a shift-add over WIDTH cycles with one bit of op_b per cycle. Latency = WIDTH+1 cycles; busy=1 throughout.
- Defined: funct7==0000001 with any other funct3 is ILLEGAL.
- Not defined: no MUL state or multiplier logic. funct7==0000001 with alu_op 10 is ILLEGAL. Decoding of all other encodings is unchanged.

Test Plan:
- Reset mid-SHIFT: SLL op_a=1, shamt=20; assert rst at cycle 5 -> out_valid=0, busy=0, result=0 immediately. First op after release completes normally.
- R-type SUB then AND back-to-back, out_ready=1: funct3 000/bit30=1 on 5,7, then 111 on 0xF0F0,0x0FF0 -> 0xFFFFFFFE (zero=0) then 0x00F0. out_valid high on consecutive cycles.
- SRA op_a=0x80000000, op_b=4 (funct3 101, bit30=1) -> out_valid 5 cycles after accept, result 0xF8000000. in_ready=0 for the 4 SHIFT cycles.
- SLT -1 vs 1 -> 1; SLTU 0xFFFFFFFF vs 1 -> 0; ADD 0xFFFFFFFF+1 -> 0 with zero=1.
- Illegal R-type funct3 100 with bit30=1 -> 1-cycle latency, illegal=1, result=0. Backpressure: out_ready=0 for 3 cycles keeps result stable and in_ready=0.
- With ALU_MUL_EN: MUL 12345*678 -> 8369910 after WIDTH+1 cycles. Without the macro, the same encoding -> illegal=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decodes alu_op / funct3 / instruction bit 30 into an RV32I-style
// operation set, executes it and returns a registered result over valid/ready.
// Shifts run one bit per cycle, so their latency is hidden behind the handshake.
//
// Optional feature macro: ALU_MUL_EN. When it is defined, R-type funct7=0000001 /
// funct3=000 is MUL, computed by a shift-add over WIDTH cycles. When it is not
// defined, that encoding is illegal and no multiplier logic exists.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready       operation handshake
//   instruccion               instruction word; [14:12] funct3, [30], [31:25] funct7
//   alu_op                    00 add, 01 sub, 10 R-type, 11 I-type
//   op_a, op_b                operands (op_b may carry an immediate)
//   out_valid / out_ready     result handshake
//   result, zero, illegal     registered result, result==0, undecodable operation
//   busy                      a multi-cycle operation is in progress
module alu_exec_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instruccion,
  input  logic [1:0]             alu_op,
  input  logic [WIDTH-1:0]       op_a,
  input  logic [WIDTH-1:0]       op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   zero,
  output logic                   illegal,
  output logic                   busy
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH for the multiplier.
  localparam int unsigned CntW    = SHAMT_W + 1;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd, OpMul, OpIll
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift
`ifdef ALU_MUL_EN
    , StMul
`endif
  } state_e;

  state_e             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               illegal_q;
  logic [WIDTH-1:0]   sh_q;        // shift operand, or multiplicand when multiplying
  logic [CntW-1:0]    cnt_q;
  logic               sh_left_q;
  logic               sh_arith_q;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   acc_next;
`endif

  // Fixed 32-bit view so funct7 decodes even when INSTR_WIDTH is 31.
  logic [31:0]        instr32;
  logic [2:0]         funct3;
  logic               bit30;
  logic [6:0]         funct7;
  logic [SHAMT_W-1:0] shamt;
  op_e                op;
  logic               is_shift;
  logic               start_shift;
  logic               accept;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   sh_next;
  logic               unused_instr;

  assign unused_instr = ^instruccion;

  // Shared R/I table; itype makes funct3 000 always ADD.
  function automatic op_e decode_tbl(input logic [2:0] f3, input logic b30, input logic itype);
    op_e res;
    case (f3)
      3'b000:  res = (b30 && !itype) ? OpSub : OpAdd;
      3'b001:  res = b30 ? OpIll : OpSll;
      3'b010:  res = b30 ? OpIll : OpSlt;
      3'b011:  res = b30 ? OpIll : OpSltu;
      3'b100:  res = b30 ? OpIll : OpXor;
      3'b101:  res = b30 ? OpSra : OpSrl;
      3'b110:  res = b30 ? OpIll : OpOr;
      default: res = b30 ? OpIll : OpAnd;
    endcase
    return res;
  endfunction

  always_comb begin
    instr32 = 32'(instruccion);
    funct3  = instr32[14:12];
    bit30   = instr32[30];
    funct7  = instr32[31:25];
    shamt   = op_b[SHAMT_W-1:0];
    op      = OpIll;
    case (alu_op)
      2'b00: op = OpAdd;
      2'b01: op = OpSub;
      2'b10: begin
        if (funct7 == 7'b0000001) begin
`ifdef ALU_MUL_EN
          op = (funct3 == 3'b000) ? OpMul : OpIll;
`else
          op = OpIll;
`endif
        end else begin
          op = decode_tbl(funct3, bit30, 1'b0);
        end
      end
      default: op = decode_tbl(funct3, bit30, 1'b1);
    endcase
  end

  assign is_shift    = (op == OpSll) || (op == OpSrl) || (op == OpSra);
  assign start_shift = is_shift && (shamt != '0);
  assign in_ready    = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;

  // Single-cycle results; a shift by zero passes op_a through.
  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:                alu_res = op_a + op_b;
      OpSub:                alu_res = op_a - op_b;
      OpSll, OpSrl, OpSra:  alu_res = op_a;
      OpSlt:                alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OpSltu:               alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      OpXor:                alu_res = op_a ^ op_b;
      OpOr:                 alu_res = op_a | op_b;
      OpAnd:                alu_res = op_a & op_b;
      default:              alu_res = '0;
    endcase
  end

  always_comb begin
    sh_next = '0;
    if (sh_left_q) begin
      sh_next = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      sh_next = {sh_arith_q & sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    end
  end

`ifdef ALU_MUL_EN
  assign acc_next = acc_q + (mplier_q[0] ? sh_q : '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      sh_left_q   <= 1'b0;
      sh_arith_q  <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q       <= '0;
      mplier_q    <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (start_shift) begin
              state_q     <= StShift;
              out_valid_q <= 1'b0;
              sh_q        <= op_a;
              cnt_q       <= {1'b0, shamt};
              sh_left_q   <= (op == OpSll);
              sh_arith_q  <= (op == OpSra);
            end
`ifdef ALU_MUL_EN
            else if (op == OpMul) begin
              state_q     <= StMul;
              out_valid_q <= 1'b0;
              sh_q        <= op_a;
              mplier_q    <= op_b;
              acc_q       <= '0;
              cnt_q       <= CntW'(WIDTH);
            end
`endif
            else begin
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              illegal_q   <= (op == OpIll);
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        StShift: begin
          sh_q  <= sh_next;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b1;
            result_q    <= sh_next;
            zero_q      <= (sh_next == '0);
            illegal_q   <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        StMul: begin
          acc_q    <= acc_next;
          sh_q     <= {sh_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b1;
            result_q    <= acc_next;
            zero_q      <= (acc_next == '0);
            illegal_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q != StIdle);

endmodule
